// File: rtl/prog_sequencer.sv
// Program sequencer: replays a loadable instruction buffer onto the CPU din bus
// using the control unit's run/done handshake, with a per-instruction timeout.
module prog_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              done,
    output logic              run,
    output logic [15:0]       din,
    output logic              busy,
    output logic              finished,
    output logic [ADDR_W-1:0] pc,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, FINISH} state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_clamp;
    logic [ADDR_W:0]   pc_plus1;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last;
    logic              is_mvi;
    logic              expire;
    logic              accept;
    logic              pc_adv;
    logic              err_set;

    assign len_clamp = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    assign pc_plus1  = {1'b0, pc} + 1'b1;
    assign last      = (pc_plus1 >= len);
    // din holds buf[pc] during ISSUE, so the opcode can be decoded from it directly
    assign is_mvi    = (din[8:6] == 3'b001);
    assign cnt_inc   = cnt + 1'b1;
    assign expire    = (cnt_inc == TIMEOUT_CNT);

    assign run      = (state == ISSUE) || (state == IMM) || (state == WAIT);
    assign busy     = (state != IDLE);
    assign finished = (state == FINISH);

    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pc_adv     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (prog_len == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (is_mvi) begin
                    if (last) begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        pc_adv     = 1'b1;
                        state_next = IMM;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            IMM, WAIT: begin
                // done takes priority over a timeout expiring in the same cycle
                if (done) begin
                    if (last) begin
                        state_next = FINISH;
                    end else begin
                        pc_adv     = 1'b1;
                        state_next = ISSUE;
                    end
                end else if (expire) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            pc    <= '0;
            din   <= '0;
            err   <= 1'b0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                err <= 1'b0;
                pc  <= '0;
                len <= len_clamp;
                din <= mem[0];
            end else if (err_set) begin
                err <= 1'b1;
            end
            if (pc_adv) begin
                pc  <= pc_plus1[ADDR_W-1:0];
                din <= mem[pc_plus1[ADDR_W-1:0]];
            end
            // cycles elapsed since the current instruction was issued
            if (state_next == ISSUE)
                cnt <= '0;
            else if (run)
                cnt <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: the CU handshake is driven by hand,
// cycle by cycle, with expected outputs written as constants.
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic [4:0]  prog_len;
    logic        done;
    logic        run;
    logic [15:0] din;
    logic        busy;
    logic        finished;
    logic [3:0]  pc;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    prog_sequencer #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .prog_len  (prog_len),
        .done      (done),
        .run       (run),
        .din       (din),
        .busy      (busy),
        .finished  (finished),
        .pc        (pc),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    // returns positioned in the first cycle after the start edge
    task automatic go(input logic [4:0] len);
        prog_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        resetn = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; prog_len = '0; done = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_run", run, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", finished, 0);
        chk("rst_pc", pc, 0);
        chk("rst_err", err, 0);
        #10 resetn = 1'b1;

        // mvi r2,#5
        load(0, 16'h0050); load(1, 16'h0005);
        go(2);
        chk("a_run1", run, 1); chk("a_din1", din, 16'h0050);
        chk("a_busy1", busy, 1); chk("a_pc1", pc, 0);
        step();
        chk("a_run2", run, 1); chk("a_din2", din, 16'h0005); chk("a_pc2", pc, 1);
        done = 1'b1; step(); done = 1'b0;
        chk("a_fin3", finished, 1); chk("a_run3", run, 0); chk("a_err3", err, 0);
        step();
        chk("a_fin4", finished, 0); chk("a_busy4", busy, 0); chk("a_din4", din, 16'h0005);

        // mv r0,r1 ; add r0,r2
        load(0, 16'h0001); load(1, 16'h0082);
        go(2);
        chk("b_pc1", pc, 0); chk("b_din1", din, 16'h0001);
        step();
        chk("b_pc2", pc, 0); chk("b_run2", run, 1);
        done = 1'b1; step(); done = 1'b0;
        chk("b_pc3", pc, 1); chk("b_din3", din, 16'h0082); chk("b_fin3", finished, 0);
        step(); chk("b_pc4", pc, 1);
        step(); chk("b_pc5", pc, 1);
        step(); chk("b_pc6", pc, 1); chk("b_run6", run, 1);
        done = 1'b1; step(); done = 1'b0;
        chk("b_fin7", finished, 1); chk("b_run7", run, 0);
        step();

        // mvi missing its immediate
        load(0, 16'h0050);
        go(1);
        chk("c_run1", run, 1);
        step();
        chk("c_err2", err, 1); chk("c_run2", run, 0); chk("c_busy2", busy, 0);
        chk("c_fin2", finished, 0);
        step();
        chk("c_fin3", finished, 0);

        // hung CU: timeout after 8 cycles from issue
        load(0, 16'h0001);
        go(1);
        repeat (7) step();
        chk("d_run8", run, 1); chk("d_err8", err, 0);
        step();
        chk("d_run9", run, 0); chk("d_err9", err, 1);
        chk("d_busy9", busy, 0); chk("d_fin9", finished, 0);
        step();
        chk("d_sticky", err, 1);
        // restart clears err; done on the last allowed cycle beats the timeout
        go(1);
        chk("d_errclr", err, 0); chk("d_rerun", run, 1);
        repeat (7) step();
        done = 1'b1; step(); done = 1'b0;
        chk("d_donewin_fin", finished, 1); chk("d_donewin_err", err, 0);
        step();

        // load and start while busy are ignored
        go(2);
        load_en = 1'b1; load_addr = 4'd0; load_data = 16'hFFFF;
        start = 1'b1; prog_len = 5'd0;
        step();
        load_en = 1'b0; start = 1'b0;
        chk("e_pc2", pc, 0); chk("e_din2", din, 16'h0001);
        chk("e_busy2", busy, 1); chk("e_fin2", finished, 0);
        done = 1'b1; step(); done = 1'b0;
        chk("e_din3", din, 16'h0082); chk("e_pc3", pc, 1);
        repeat (3) step();
        done = 1'b1; step(); done = 1'b0;
        chk("e_fin7", finished, 1);
        step();
        go(1);
        chk("e_bufkept", din, 16'h0001);
        step();
        done = 1'b1; step(); done = 1'b0;
        chk("e_fin_b", finished, 1);
        step();

        // zero-length program
        go(0);
        chk("f_fin", finished, 1); chk("f_run", run, 0);
        step();
        chk("f_fin2", finished, 0); chk("f_busy2", busy, 0); chk("f_err2", err, 0);

        // asynchronous reset in the middle of the add
        go(2);
        step();
        done = 1'b1; step(); done = 1'b0;
        step();
        chk("g_pre_pc", pc, 1);
        #1 resetn = 1'b0;
        #1;
        chk("g_run", run, 0); chk("g_busy", busy, 0); chk("g_pc", pc, 0);
        chk("g_din", din, 0); chk("g_err", err, 0); chk("g_fin", finished, 0);
        #1 resetn = 1'b1;
        step();
        chk("g_idle", busy, 0);
        go(2);
        chk("g_pc1", pc, 0); chk("g_din1", din, 16'h0001); chk("g_run1", run, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer for the 16-bit sequential CPU. It is the initiator side of the control unit's run/done handshake. It holds a small loadable program buffer and presents each instruction word on `din` with `run` asserted. For `mvi` it supplies the immediate word on the following cycle, then waits for `done` before issuing the next word. It sits between the testbench/host loader and the CPU datapath's `din` input.

## Interface
- `DEPTH`, 16: program buffer words (power of 2)
- `ADDR_W`, 4: log2(DEPTH)
- `TIMEOUT`, 8: max cycles from issue to `done` before abort
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  reset, asynchronous, active-low
- `load_en`  in  1  write `load_data` into buffer at `load_addr`
- `load_addr`  in  ADDR_W  buffer write address
- `load_data`  in  16  buffer write data
- `start`  in  1  begin execution at address 0
- `prog_len`  in  ADDR_W+1  words to execute; values above DEPTH clamp to DEPTH
- `done`  in  1  CU instruction-complete strobe
- `run`  out  1  CU run enable
- `din`  out  16  word to CPU `din`; IR is taken from `din[8:0]`, opcode `din[8:6]`
- `busy`  out  1  program executing
- `finished`  out  1  one-cycle pulse on normal completion
- `pc`  out  ADDR_W  address of the word currently on `din`
- `err`  out  1  sticky abort flag; cleared by next accepted `start`

## Operation
- Buffer: DEPTH x 16 registers, written synchronously when `load_en`=1 and `busy`=0.
  - Writes while `busy`=1 are dropped.
  - The buffer is not cleared by reset.
- FSM states: IDLE, ISSUE, IMM, WAIT, FINISH.
- IDLE:
  - `run`=0, `busy`=0.
  - `start`=1 with `prog_len`>0: clear `err`, `pc`<=0, go ISSUE.
  - `start` with `prog_len`=0: pulse `finished` next cycle; no `run`.
- ISSUE (CU T0):
  - `run`=1, `din`=buf[pc].
  - If opcode=3'b001 (mvi): if pc+1 >= len, set `err` and go IDLE (missing immediate). Otherwise `pc`<=pc+1 and go IMM.
  - Any other opcode: go WAIT.
- IMM (CU T1): `run`=1, `din`=buf[pc] (immediate). `done` sampled here is valid.
- WAIT: `run`=1, `din` holds last driven word until `done`.
- On `done`=1 sampled in IMM or WAIT:
  - If pc+1 >= len, go FINISH.
  - Else `pc`<=pc+1 and go ISSUE. There is no idle gap between instructions.
- `done` in ISSUE is ignored.
- FINISH: `run`=0, `finished`=1 for exactly one cycle, then IDLE. `din` holds its last value.
- Timeout:
  - A counter resets on entry to ISSUE and increments each cycle in IMM/WAIT.
  - If it reaches TIMEOUT without `done`: set `err`, drop `run`, go IDLE (no `finished`).
- `start` while `busy` is ignored.
- Unknown opcodes (100–111) are issued like mv/add. Detecting them is the CU's responsibility, and the timeout catches a hung CU.

## Timing
- Reset values: `run`=0, `din`=16'h0000, `busy`=0, `finished`=0, `pc`=0, `err`=0, FSM=IDLE, timeout counter=0.
- Reset is asynchronous. Asserting `resetn` mid-program forces all outputs to reset values immediately, and the program is abandoned.
- `busy`=1 from the cycle after accepted `start` through the FINISH cycle.
- Latency, `start` to first `run`=1: 1 cycle.
- mv/mvi: the `done` cycle is the 2nd cycle of the instruction. The next ISSUE follows on the cycle after, so each instruction is 2 cycles.
- add/sub: `done` on the 4th cycle, so each instruction is 4 cycles.
- `din` changes only on clock edges. It is stable for the whole ISSUE cycle (IR load) and the whole IMM cycle (immediate capture).
- `done` and timeout expiry in the same cycle: `done` wins.

## Test plan
- Reset mid-program: assert `resetn`=0 during WAIT.
  - Outputs go to 0 without waiting for a clock.
  - After release, `start` runs the program from pc 0 again.
- Load {0x0050, 0x0005} (mvi r2,#5), `prog_len`=2, `start`, CU model gives `done` in cycle 2.
  - `din`=0x0050 then 0x0005 with `run`=1.
  - `finished` pulses on cycle 3, `err`=0.
- Load {0x0001, 0x0082} (mv r0,r1; add r0,r2), `prog_len`=2.
  - `pc` reads 0,0,1,1,1,1.
  - `din` switches to 0x0082 the cycle after the first `done`.
  - `finished` follows the 4th add cycle.
- `prog_len`=1 with buf[0]=0x0050 (mvi with no immediate): `err`=1 after the ISSUE cycle, `run` drops, no `finished`.
- CU model never asserts `done`, TIMEOUT=8: `err`=1 and `run`=0 exactly 8 cycles after ISSUE. A later `start` clears `err`.
- `load_en` and a second `start` while `busy`: buffer is unchanged and execution is unaffected. `prog_len`=0: `finished` pulses with no `run`.
